// File: rtl/axi_ram_slave.sv
// AXI4 slave in front of a byte-strobed dual-port RAM. Independent write and read engines
// handle FIXED/INCR/WRAP bursts, narrow beats, backpressure and SLVERR on WLAST mismatch.
module axi_ram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int NB      = $clog2(STRB_WIDTH);
  localparam int WORD_AW = ADDR_WIDTH - NB;
  localparam int DEPTH   = 2 ** WORD_AW;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_PRIME, R_LOAD, R_DATA} r_state_e;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'(NB)) ? 3'(NB) : size;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [7:0]            len,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] bound;
    incr  = ONE << size;
    bound = (ADDR_WIDTH'(len) + ONE) * incr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~(bound - ONE)) | ((addr + incr) & (bound - ONE));
      default:     next_addr = (addr & ~(incr - ONE)) + incr;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- write engine
  w_state_e              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_count;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  w_fire;
  logic                  w_last_beat;

  assign w_fire      = s_axi_wvalid && s_axi_wready;
  assign w_last_beat = (w_count == w_len);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_count       <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            s_axi_bid     <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= clamp_size(s_axi_awsize);
            w_burst       <= s_axi_awburst;
            w_count       <= '0;
            w_err         <= 1'b0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            // The beat count alone ends the burst; a misplaced WLAST only flags the error.
            if (w_last_beat) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end else begin
              w_err   <= w_err | s_axi_wlast;
              w_count <= w_count + 8'd1;
              w_addr  <= next_addr(w_addr, w_size, w_len, w_burst);
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; contents survive rst and only the control path restarts.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[w_addr[ADDR_WIDTH-1:NB]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read engine
  r_state_e              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_next;
  logic [7:0]            r_len;
  logic [7:0]            r_count;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_load;
  logic [WORD_AW-1:0]    rd_word;
  logic [DATA_WIDTH-1:0] ram_q;

  // r_addr is the beat to load next; the RAM always looks at the address r_addr will hold
  // after this edge, so ram_q is ready whenever the output register takes a new beat.
  assign r_load  = (r_state == R_LOAD) || (s_axi_rvalid && s_axi_rready && !s_axi_rlast);
  assign r_next  = next_addr(r_addr, r_size, r_len, r_burst);
  assign rd_word = r_load ? r_next[ADDR_WIDTH-1:NB] : r_addr[ADDR_WIDTH-1:NB];
  assign s_axi_rresp = RESP_OKAY;

  always_ff @(posedge clk) begin
    ram_q <= mem[rd_word];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_count       <= '0;
      r_size        <= '0;
      r_burst       <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rid     <= s_axi_arid;
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= clamp_size(s_axi_arsize);
            r_burst       <= s_axi_arburst;
            r_count       <= '0;
            r_state       <= R_PRIME;
          end
        end
        R_PRIME: r_state <= R_LOAD;
        R_LOAD: begin
          s_axi_rdata  <= ram_q;
          s_axi_rvalid <= 1'b1;
          s_axi_rlast  <= (r_len == 8'd0);
          r_addr       <= r_next;
          r_state      <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              s_axi_rdata <= ram_q;
              s_axi_rlast <= (r_count + 8'd1 == r_len);
              r_count     <= r_count + 8'd1;
              r_addr      <= r_next;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
